// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM: IDLE -> DECODE -> EXEC -> (MEM) -> WB with registered outputs.
// Latency accept-to-done: 3 cycles (R-type/addi/ori/sw), 4 cycles (lw); err on bad decode or ALU overflow.
// Backpressure: start is honoured only while ready (IDLE); it is ignored in every other state.
module mips_mc_ctrl #(
   parameter int DW           = 32,
   parameter int ZERO_PROTECT = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [DW-1:0] instr,
   output logic          ready,
   output logic          done,
   output logic          err,
   input  logic [DW-1:0] alu_result,
   input  logic          alu_ovf,
   output logic [4:0]    rgr1,
   output logic [4:0]    rgr2,
   output logic [4:0]    rgw1,
   output logic [DW-1:0] imm,
   output logic          alu_src,
   output logic [3:0]    alu_ctrl,
   output logic          reg_write,
   output logic          mem_read,
   output logic          mem_write,
   output logic [DW-1:0] mem_addr,
   output logic          wb_sel
);

   typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB} state_t;

   state_t        state;
   logic          is_lw, is_sw, ovf_chk;
   logic          d_ok, d_rt, d_lw, d_sw, d_ovc;
   logic [3:0]    d_ctl;
   logic [4:0]    d_wr;
   logic [DW-1:0] d_imm, sx, zx;
   logic          wr_ok;
   wire           unused = &{1'b0, instr[10:6]};

   // Decode straight off the instr bus so the latched fields are valid in DECODE.
   always_comb begin
      d_ok  = 1'b0;
      d_rt  = 1'b0;
      d_lw  = 1'b0;
      d_sw  = 1'b0;
      d_ovc = 1'b0;
      d_ctl = 4'b0000;
      d_wr  = 5'd0;
      d_imm = '0;
      sx    = {{(DW-16){instr[15]}}, instr[15:0]};
      zx    = {{(DW-16){1'b0}}, instr[15:0]};
      case (instr[31:26])
         6'b000000: begin
            d_rt = 1'b1;
            d_wr = instr[15:11];
            case (instr[5:0])
               6'b100000: begin d_ok = 1'b1; d_ovc = 1'b1; d_ctl = 4'b0000; end
               6'b100010: begin d_ok = 1'b1; d_ovc = 1'b1; d_ctl = 4'b0001; end
               6'b100100: begin d_ok = 1'b1; d_ctl = 4'b0100; end
               6'b100101: begin d_ok = 1'b1; d_ctl = 4'b0101; end
               6'b101010: begin d_ok = 1'b1; d_ctl = 4'b0111; end
               default: ;
            endcase
         end
         6'b001000: begin d_ok = 1'b1; d_ovc = 1'b1; d_wr = instr[20:16]; d_imm = sx; end
         6'b001101: begin d_ok = 1'b1; d_ctl = 4'b0101; d_wr = instr[20:16]; d_imm = zx; end
         6'b100011: begin d_ok = 1'b1; d_lw = 1'b1; d_wr = instr[20:16]; d_imm = sx; end
         6'b101011: begin d_ok = 1'b1; d_sw = 1'b1; d_imm = sx; end
         default: ;
      endcase
   end

   assign wr_ok = !((ZERO_PROTECT != 0) && (rgw1 == 5'd0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ready     <= 1'b1;
         done      <= 1'b0;
         err       <= 1'b0;
         rgr1      <= '0;
         rgr2      <= '0;
         rgw1      <= '0;
         imm       <= '0;
         alu_src   <= 1'b0;
         alu_ctrl  <= '0;
         reg_write <= 1'b0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         wb_sel    <= 1'b0;
         is_lw     <= 1'b0;
         is_sw     <= 1'b0;
         ovf_chk   <= 1'b0;
      end else begin
         done      <= 1'b0;
         err       <= 1'b0;
         reg_write <= 1'b0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         wb_sel    <= 1'b0;
         case (state)
            IDLE: if (start) begin
               state    <= DECODE;
               ready    <= 1'b0;
               err      <= !d_ok;
               rgr1     <= instr[25:21];
               rgr2     <= instr[20:16];
               rgw1     <= d_wr;
               imm      <= d_imm;
               alu_src  <= !d_rt;
               alu_ctrl <= d_ctl;
               is_lw    <= d_lw;
               is_sw    <= d_sw;
               ovf_chk  <= d_ovc;
            end
            // err is only ever high in DECODE for an unsupported encoding.
            DECODE: if (err) begin
               state <= IDLE;
               ready <= 1'b1;
            end else begin
               state <= EXEC;
            end
            EXEC: begin
               mem_addr <= alu_result;
               if (ovf_chk && alu_ovf) begin
                  state <= IDLE;
                  ready <= 1'b1;
                  err   <= 1'b1;
               end else if (is_lw) begin
                  state    <= MEM;
                  mem_read <= 1'b1;
               end else if (is_sw) begin
                  state     <= MEM;
                  mem_write <= 1'b1;
                  done      <= 1'b1;
               end else begin
                  state     <= WB;
                  reg_write <= wr_ok;
                  done      <= 1'b1;
               end
            end
            MEM: if (is_lw) begin
               state     <= WB;
               reg_write <= wr_ok;
               wb_sel    <= 1'b1;
               done      <= 1'b1;
            end else begin
               state <= IDLE;
               ready <= 1'b1;
            end
            WB: begin
               state <= IDLE;
               ready <= 1'b1;
            end
            default: begin
               state <= IDLE;
               ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed + random bench for mips_mc_ctrl against an instruction-level reference model.
module tb_mips_mc_ctrl;

   logic        clk = 1'b0;
   logic        rst_n, start, alu_ovf;
   logic [31:0] instr, alu_result;
   logic        ready, done, err, alu_src, reg_write, mem_read, mem_write, wb_sel;
   logic [4:0]  rgr1, rgr2, rgw1;
   logic [31:0] imm, mem_addr;
   logic [3:0]  alu_ctrl;

   int n_chk  = 0;
   int n_pass = 0;

   mips_mc_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .instr(instr),
      .ready(ready), .done(done), .err(err),
      .alu_result(alu_result), .alu_ovf(alu_ovf),
      .rgr1(rgr1), .rgr2(rgr2), .rgw1(rgw1), .imm(imm),
      .alu_src(alu_src), .alu_ctrl(alu_ctrl), .reg_write(reg_write),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .wb_sel(wb_sel)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         ok;
      bit         rt;
      bit         ld;
      bit         st;
      bit         ovc;
      logic [3:0] ctl;
      logic [4:0] wr;
      logic [31:0] im;
   } dec_t;

   // Instruction-set level meaning of each encoding.
   function automatic dec_t ref_dec(input logic [31:0] i);
      dec_t d = '{default: 0};
      logic [31:0] sx = {{16{i[15]}}, i[15:0]};
      logic [31:0] zx = {16'h0000, i[15:0]};
      case (i[31:26])
         6'h00: begin
            d.rt = 1; d.wr = i[15:11];
            case (i[5:0])
               6'h20: begin d.ok = 1; d.ovc = 1; d.ctl = 4'd0; end
               6'h22: begin d.ok = 1; d.ovc = 1; d.ctl = 4'd1; end
               6'h24: begin d.ok = 1; d.ctl = 4'd4; end
               6'h25: begin d.ok = 1; d.ctl = 4'd5; end
               6'h2a: begin d.ok = 1; d.ctl = 4'd7; end
               default: ;
            endcase
         end
         6'h08: begin d.ok = 1; d.ovc = 1; d.ctl = 4'd0; d.wr = i[20:16]; d.im = sx; end
         6'h0d: begin d.ok = 1; d.ctl = 4'd5; d.wr = i[20:16]; d.im = zx; end
         6'h23: begin d.ok = 1; d.ld = 1; d.ctl = 4'd0; d.wr = i[20:16]; d.im = sx; end
         6'h2b: begin d.ok = 1; d.st = 1; d.ctl = 4'd0; d.im = sx; end
         default: ;
      endcase
      return d;
   endfunction

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Issue one instruction at the current negedge and check every cycle until IDLE.
   task automatic run(input logic [31:0] ins, input logic [31:0] ares, input logic ovf, input string tag);
      dec_t d;
      int idle_c, done_c, err_c, rw_c, mr_c, mw_c;
      d = ref_dec(ins);
      done_c = 0; err_c = 0; rw_c = 0; mr_c = 0; mw_c = 0;
      if (!d.ok) begin
         err_c = 1; idle_c = 2;
      end else if (d.ovc && ovf) begin
         err_c = 3; idle_c = 3;
      end else if (d.ld) begin
         mr_c = 3; done_c = 4; rw_c = (d.wr != 0) ? 4 : 0; idle_c = 5;
      end else if (d.st) begin
         mw_c = 3; done_c = 3; idle_c = 4;
      end else begin
         done_c = 3; rw_c = (d.wr != 0) ? 3 : 0; idle_c = 4;
      end
      instr = ins; start = 1'b1; alu_result = ares; alu_ovf = ovf;
      for (int k = 1; k <= idle_c; k++) begin
         @(negedge clk);
         start = 1'($urandom_range(0, 1));
         instr = $urandom;
         chk($sformatf("%s_ctl_c%0d", tag, k),
             {90'd0, ready, done, err, reg_write, mem_read, mem_write},
             {90'd0, k >= idle_c, k == done_c, k == err_c, k == rw_c, k == mr_c, k == mw_c});
         if (d.ok && k == 1) begin
            chk({tag, "_ops"}, {rgr1, rgr2, alu_src, alu_ctrl},
                {ins[25:21], ins[20:16], !d.rt, d.ctl});
            if (!d.rt) chk({tag, "_imm"}, imm, d.im);
            if (!d.st) chk({tag, "_rgw1"}, rgw1, d.wr);
         end
         if (d.ok && k == 3 && (d.ld || d.st) && err_c == 0)
            chk({tag, "_maddr"}, mem_addr, ares);
         if (k == done_c && !d.st)
            chk({tag, "_wbsel"}, wb_sel, d.ld);
      end
      start = 1'b0;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] r = $urandom;
      logic [5:0] ops [7] = '{6'h00, 6'h00, 6'h08, 6'h0d, 6'h23, 6'h2b, 6'h3f};
      logic [5:0] fns [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h21};
      r[31:26] = ops[$urandom_range(0, 6)];
      if (r[31:26] == 6'h00) r[5:0] = fns[$urandom_range(0, 5)];
      return r;
   endfunction

   initial begin
      rst_n = 1'b0; start = 1'b0; instr = '0; alu_result = '0; alu_ovf = 1'b0;
      #12;
      chk("rst_flags", {ready, done, err, reg_write, mem_read, mem_write, alu_src, wb_sel},
          8'b1000_0000);
      chk("rst_buses", {rgr1, rgr2, rgw1, alu_ctrl, imm, mem_addr}, 96'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run(32'h00225020, 32'h0000_1234, 1'b0, "add");
      run(32'h348B0001, 32'h0000_0005, 1'b0, "ori");
      run(32'h8C25FFFC, 32'h0000_0100, 1'b0, "lw");
      run(32'hFC000000, 32'h0000_0000, 1'b0, "badop");
      run(32'h00225020, 32'h8000_0000, 1'b1, "addovf");
      run(32'h00220020, 32'h0000_0001, 1'b0, "addrd0");
      run(32'h00435022, 32'h0000_0002, 1'b1, "subovf");
      run(32'h2022FFFF, 32'h0000_0007, 1'b0, "addi");
      run(32'hAC450010, 32'h0000_0200, 1'b0, "sw");

      // Reset dropped while a store is in MEM.
      instr = 32'hAC450010; alu_result = 32'h0000_0300; alu_ovf = 1'b0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("sw_mem_before_rst", {ready, done, mem_write}, 3'b011);
      #2 rst_n = 1'b0;
      #1 chk("sw_mid_rst", {ready, done, err, reg_write, mem_read, mem_write, mem_addr[7:0]},
             14'b10_0000_0000_0000);
      @(negedge clk);
      rst_n = 1'b1;
      run(32'h00225025, 32'h0000_0009, 1'b0, "after_rst");

      for (int n = 0; n < 60; n++)
         run(rand_instr(), $urandom, ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", n));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
